// File: rtl/masked_bv4_theta_pipe_if.sv
// rtl/masked_bv4_theta_pipe_if.sv - handshake and data bundle for masked_bv4_theta_pipe
// Ports (slave view, as seen by the pipe):
//   in_a            in   shared GF(2^4) inputs per lane/share; [3:2]=Gamma_1, [1:0]=Gamma_0
//   in_valid        in   in_a valid
//   in_ready        out  pipe accepts this cycle
//   in_random       in   fresh randomness, lane k uses slice k = {r, p}
//   in_random_valid in   in_random is fresh
//   out_b           out  shared GF(2^2) Theta per lane/share
//   out_valid       out  out_b valid
//   out_ready       in   downstream accepts
interface masked_bv4_theta_pipe_if #(
  parameter int NUM_SHARES = 2,
  parameter int NUM_LANES  = 1
);
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int NUM_RANDOM    = NUM_LANES * 2 * (NUM_QUADRATIC * 2);

  typedef logic [3:0] bv4_t;
  typedef logic [1:0] bv2_t;

  bv4_t [NUM_LANES-1:0][NUM_SHARES-1:0] in_a;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_RANDOM-1:0]                in_random;
  logic                                 in_random_valid;
  bv2_t [NUM_LANES-1:0][NUM_SHARES-1:0] out_b;
  logic                                 out_valid;
  logic                                 out_ready;

  modport slave (
    input  in_a, in_valid, in_random, in_random_valid, out_ready,
    output in_ready, out_b, out_valid
  );

  modport master (
    output in_a, in_valid, in_random, in_random_valid, out_ready,
    input  in_ready, out_b, out_valid
  );
endinterface

// File: rtl/masked_bv4_theta_pipe.sv
// rtl/masked_bv4_theta_pipe.sv - multi-lane handshaked masked Theta stage of the GF(2^4) inverter
// Ports:
//   in_clock  in  rising-edge clock
//   in_reset  in  asynchronous active-high reset
//   bus       slave modport of masked_bv4_theta_pipe_if (in_a/in_valid/in_ready,
//             in_random/in_random_valid, out_b/out_valid/out_ready)
// GF(2^2) uses the polynomial basis {w, 1} with w^2 = w + 1; sigma = w.
module masked_bv4_theta_pipe #(
  parameter int NUM_SHARES = 2,
  parameter int NUM_LANES  = 1,
  parameter int OUT_REG    = 0
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  masked_bv4_theta_pipe_if.slave  bus
);
  typedef logic [1:0] bv2_t;

  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int NUM_RANDOM    = NUM_LANES * 2 * (NUM_QUADRATIC * 2);
  localparam int LANE_RANDOM   = NUM_RANDOM / NUM_LANES;

  function automatic bv2_t bv2_mul(input bv2_t a, input bv2_t b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic bv2_t bv2_sq(input bv2_t a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic bv2_t bv2_scl_sigma(input bv2_t a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  // Index of the unordered share pair (i, j), i < j, into the r/p vectors.
  function automatic int pair_idx(input int i, input int j);
    return i * NUM_SHARES - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic v1;
  logic acc;
  logic s1_dn_ready;
  bv2_t [NUM_LANES-1:0][NUM_SHARES-1:0] s1_b;

  assign bus.in_ready = !in_reset && (!v1 || s1_dn_ready);
  assign acc          = bus.in_valid && bus.in_random_valid && bus.in_ready;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset)         v1 <= 1'b0;
    else if (acc)         v1 <= 1'b1;
    else if (s1_dn_ready) v1 <= 1'b0;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bv2_t [NUM_QUADRATIC-1:0]               r, p;
    bv2_t [NUM_SHARES-1:0]                  g1, g0, g1_q, g0_q, lane_b;
    bv2_t [NUM_SHARES-1:0][NUM_SHARES-1:0]  u_d, v_d, u_q, v_q;

    assign {r, p} = bus.in_random[l*LANE_RANDOM +: LANE_RANDOM];

    // HPC3 gadget, input side. Diagonal of u holds a_i*b_i; diagonal of v
    // stays zero so the output side can fold every (i, j) uniformly.
    always_comb begin
      int k;
      g1  = '0;
      g0  = '0;
      u_d = '0;
      v_d = '0;
      for (int i = 0; i < NUM_SHARES; i++) begin
        g1[i] = bus.in_a[l][i][3:2];
        g0[i] = bus.in_a[l][i][1:0];
      end
      for (int i = 0; i < NUM_SHARES; i++) begin
        for (int j = 0; j < NUM_SHARES; j++) begin
          if (i == j) begin
            u_d[i][j] = bv2_mul(g1[i], g0[i]);
          end else begin
            k = (i < j) ? pair_idx(i, j) : pair_idx(j, i);
            u_d[i][j] = bv2_mul(g1[i], g0[j] ^ r[k]);
            // (a_i + 1) * r + p: paired with a_i * r above, r cancels across (i,j)/(j,i)
            v_d[i][j] = bv2_mul(g1[i] ^ 2'b01, r[k]) ^ p[k];
          end
        end
      end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        u_q  <= '0;
        v_q  <= '0;
        g1_q <= '0;
        g0_q <= '0;
      end else if (acc) begin
        u_q  <= u_d;
        v_q  <= v_d;
        g1_q <= g1;
        g0_q <= g0;
      end
    end

    // Squaring and sigma scaling are linear, so they apply share-wise.
    always_comb begin
      bv2_t m;
      lane_b = '0;
      for (int i = 0; i < NUM_SHARES; i++) begin
        m = '0;
        for (int j = 0; j < NUM_SHARES; j++) m = m ^ u_q[i][j] ^ v_q[i][j];
        lane_b[i] = bv2_sq(m ^ bv2_scl_sigma(bv2_sq(g1_q[i] ^ g0_q[i])));
      end
    end

    assign s1_b[l] = lane_b;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic v2;
    bv2_t [NUM_LANES-1:0][NUM_SHARES-1:0] s2_b;

    assign s1_dn_ready = !v2 || bus.out_ready;

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        v2   <= 1'b0;
        s2_b <= '0;
      end else if (v1 && s1_dn_ready) begin
        v2   <= 1'b1;
        s2_b <= s1_b;
      end else if (bus.out_ready) begin
        v2   <= 1'b0;
      end
    end

    assign bus.out_valid = v2;
    assign bus.out_b     = s2_b;
  end else begin : g_out_comb
    assign s1_dn_ready   = bus.out_ready;
    assign bus.out_valid = v1;
    assign bus.out_b     = s1_b;
  end
endmodule

// File: tb/tb_masked_bv4_theta_pipe.sv
// tb/tb_masked_bv4_theta_pipe.sv - directed and randomised bench for masked_bv4_theta_pipe
module tb_masked_bv4_theta_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  masked_bv4_theta_pipe_if #(.NUM_SHARES(2), .NUM_LANES(1)) if0 ();
  masked_bv4_theta_pipe_if #(.NUM_SHARES(3), .NUM_LANES(4)) if1 ();

  masked_bv4_theta_pipe #(.NUM_SHARES(2), .NUM_LANES(1), .OUT_REG(0)) dut0 (
    .in_clock(clk), .in_reset(rst), .bus(if0.slave));
  masked_bv4_theta_pipe #(.NUM_SHARES(3), .NUM_LANES(4), .OUT_REG(1)) dut1 (
    .in_clock(clk), .in_reset(rst), .bus(if1.slave));

  typedef struct {
    logic [3:0] a;
    logic [1:0] exp;
  } vec_t;
  vec_t vec[16];
  // Theta of each unshared a, hand-derived in the {w,1} basis, w^2 = w + 1, sigma = w
  logic [1:0] theta_tab[16] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd3,
                                2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd3};
  logic [3:0] rv_a[4]  = '{4'h3, 4'h6, 4'hC, 4'h9};
  logic       rv_on[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } sb_t;
  sb_t sbq[$];
  int  n_acc = 0;
  int  n_out = 0;
  int  cyc = 0;
  bit  chk_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic [3:0] a, input logic v, input logic rv);
    logic [31:0] t;
    t = $urandom;
    if0.in_a[0][0]      = t[3:0];
    if0.in_a[0][1]      = t[3:0] ^ a;
    if0.in_random       = t[7:4];
    if0.in_valid        = v;
    if0.in_random_valid = rv;
  endtask

  task automatic drive1(input logic [15:0] vals, input logic v, input logic rv);
    logic [63:0] t;
    for (int l = 0; l < 4; l++) begin
      t = {$urandom, $urandom};
      if1.in_a[l][0] = t[3:0];
      if1.in_a[l][1] = t[7:4];
      if1.in_a[l][2] = t[3:0] ^ t[7:4] ^ vals[4*l +: 4];
    end
    t = {$urandom, $urandom};
    if1.in_random       = t[47:0];
    if1.in_valid        = v;
    if1.in_random_valid = rv;
  endtask

  function automatic logic [1:0] unsh0();
    return if0.out_b[0][0] ^ if0.out_b[0][1];
  endfunction

  function automatic logic [7:0] unsh1();
    logic [7:0] u;
    u = '0;
    for (int l = 0; l < 4; l++)
      u[2*l +: 2] = if1.out_b[l][0] ^ if1.out_b[l][1] ^ if1.out_b[l][2];
    return u;
  endfunction

  function automatic logic [7:0] exp1();
    logic [7:0] e;
    logic [3:0] a;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      a = if1.in_a[l][0] ^ if1.in_a[l][1] ^ if1.in_a[l][2];
      e[2*l +: 2] = vec[a].exp;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the OUT_REG=1 instance: pop before push, latency >= 1.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (if1.out_valid && if1.out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_out", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_value", unsh1(), e.val);
          if (chk_lat) chk("sb_latency", cyc - e.cyc, 2);
        end
      end
      if (if1.in_valid && if1.in_random_valid && if1.in_ready) begin
        sbq.push_back('{exp1(), cyc});
        n_acc++;
      end
    end
  end

  initial begin
    logic [3:0]  snap0;
    logic [23:0] snap1;
    logic [31:0] t;
    int          a0, o0, n_a, cycles;

    for (int k = 0; k < 16; k++) vec[k] = '{a: 4'(k), exp: theta_tab[k]};

    rst = 1'b1;
    drive0(4'h0, 1'b0, 1'b0);
    drive1(16'h0, 1'b0, 1'b0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    #2;
    chk("rst_valid0", if0.out_valid, 0);
    chk("rst_b0", if0.out_b, 0);
    chk("rst_ready0", if0.in_ready, 0);
    chk("rst_valid1", if1.out_valid, 0);
    chk("rst_b1", if1.out_b, 0);
    chk("rst_ready1", if1.in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", if0.in_ready, 1);
    chk("post_rst_ready1", if1.in_ready, 1);

    // Table stream, 2 shares / 1 lane / latency 1, back-to-back
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      drive0(vec[i].a, 1'b1, 1'b1);
      @(negedge clk);
      chk("tab_in_ready", if0.in_ready, 1);
      @(posedge clk);
      #1;
      chk("tab_valid", if0.out_valid, 1);
      chk($sformatf("tab_theta_a%0h", vec[i].a), unsh0(), vec[i].exp);
    end

    // Randomness-valid toggling: no accept and frozen registers when low
    for (int i = 0; i < 4; i++) begin
      drive0(rv_a[i], 1'b1, rv_on[i]);
      @(negedge clk);
      chk("rv_in_ready", if0.in_ready, 1);
      @(posedge clk);
      #1;
      if (rv_on[i]) begin
        chk("rv_valid_on", if0.out_valid, 1);
        chk("rv_theta", unsh0(), vec[rv_a[i]].exp);
        snap0 = if0.out_b;
      end else begin
        chk("rv_valid_off", if0.out_valid, 0);
        chk("rv_hold_shares", if0.out_b, snap0);
      end
    end

    // OUT_REG=0 stall: full immediately, output stable
    drive0(4'h7, 1'b1, 1'b1);
    if0.out_ready = 1'b0;
    @(negedge clk);
    chk("st0_first_ready", if0.in_ready, 1);
    @(posedge clk);
    #1;
    chk("st0_valid", if0.out_valid, 1);
    chk("st0_theta", unsh0(), vec[7].exp);
    snap0 = if0.out_b;
    drive0(4'hB, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st0_ready_low", if0.in_ready, 0);
      @(posedge clk);
      #1;
      chk("st0_stable_b", if0.out_b, snap0);
      chk("st0_stable_v", if0.out_valid, 1);
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    chk("st0_resume_ready", if0.in_ready, 1);
    @(posedge clk);
    #1;
    chk("st0_next_theta", unsh0(), vec[11].exp);
    drive0(4'h0, 1'b0, 1'b1);

    // Exhaustive 16 values over 4 lanes, 3 shares, latency 2, back-to-back
    chk_lat = 1;
    o0 = n_out;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] vals;
      for (int l = 0; l < 4; l++) vals[4*l +: 4] = 4'((i + 5 * l) % 16);
      drive1(vals, 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    drive1(16'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("exh_out_count", n_out - o0, 16);
    chk_lat = 0;

    // Back-pressure on OUT_REG=1: two accepts fill the pipe
    if1.out_ready = 1'b0;
    n_a = 0;
    for (int c = 0; c < 5; c++) begin
      t = $urandom;
      drive1(t[15:0], 1'b1, 1'b1);
      @(negedge clk);
      if (if1.in_ready) n_a++;
      if (c >= 2) chk("bp_ready_low", if1.in_ready, 0);
      if (c == 2) begin
        chk("bp_valid", if1.out_valid, 1);
        snap1 = if1.out_b;
      end
      if (c > 2) begin
        chk("bp_stable_b", if1.out_b, snap1);
        chk("bp_stable_v", if1.out_valid, 1);
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", n_a, 2);
    drive1(16'h0, 1'b0, 1'b1);
    if1.out_ready = 1'b1;
    o0 = n_out;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", n_out - o0, 2);
    chk("bp_sb_empty", sbq.size(), 0);

    // Asynchronous reset with two elements in flight
    for (int c = 0; c < 2; c++) begin
      t = $urandom;
      drive1(t[15:0], 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    drive1(16'h0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid1", if1.out_valid, 0);
    chk("ar_b1", if1.out_b, 0);
    chk("ar_b0", if0.out_b, 0);
    chk("ar_ready1", if1.in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    o0 = n_out;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ar_no_stale1", if1.out_valid, 0);
      chk("ar_no_stale0", if0.out_valid, 0);
    end

    // Randomised traffic
    a0 = n_acc;
    o0 = n_out;
    cycles = 0;
    @(posedge clk);
    #1;
    while ((n_acc - a0) < 10000 && cycles < 60000) begin
      t = $urandom;
      drive1(t[15:0], ($urandom % 4) != 0, ($urandom % 4) != 0);
      if1.out_ready = ($urandom % 10) < 7;
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("rand_budget", (n_acc - a0) >= 10000, 1);
    drive1(16'h0, 1'b0, 1'b1);
    if1.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_acc_eq_out", n_acc - a0, n_out - o0);
    chk("rand_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/masked_bv4_theta_pipe.md
# masked_bv4_theta_pipe

Multi-lane, handshaked successor to the single-lane masked Theta stage of the masked GF(2^4) inverter. Each lane takes a d-share masked GF(2^4) element a = (Gamma_1, Gamma_0) and produces the d-share masked GF(2^2) value Theta = (Gamma_1*Gamma_0 + (Gamma_1+Gamma_0)^2*Sigma)^-1. It adds what the single-lane stage lacks:

- NUM_LANES parallel lanes.
- valid/ready flow control with full back-pressure.
- A randomness-valid qualifier.
- An optional output register stage.

It sits between the masked GF(2^4) input split and the masked Theta-multiplication stage of the S-box pipeline.

## Interface
Parameters:
- NUM_SHARES, 2: number of Boolean shares d (>= 2).
- NUM_LANES, 1: independent parallel lanes (>= 1).
- OUT_REG, 0: 0 = output taken from stage 1 (latency 1); 1 = extra output register (latency 2).
- Derived: NUM_QUADRATIC = num_quad(NUM_SHARES) from aes128_package; NUM_RANDOM = NUM_LANES*2*(NUM_QUADRATIC*2).

Ports:
- in_clock  input  1  sole clock, rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_a  input  bv4_t[NUM_LANES-1:0][NUM_SHARES-1:0]  shared inputs; [3:2]=Gamma_1, [1:0]=Gamma_0.
- in_valid  input  1  in_a is valid.
- in_ready  output  1  block accepts this cycle.
- in_random  input  NUM_RANDOM  fresh randomness; lane k uses slice k, and each slice splits as {r, p}, each NUM_QUADRATIC bv2_t.
- in_random_valid  input  1  in_random is fresh.
- out_b  output  bv2_t[NUM_LANES-1:0][NUM_SHARES-1:0]  shared Theta.
- out_valid  output  1  out_b valid.
- out_ready  input  1  downstream accepts.

## Operation
- Accept: acc = in_valid & in_random_valid & in_ready. Randomness is consumed only on acc. No input register loads without acc, and no gadget register loads without acc.
- Stage 1, per lane:
  - HPC3 gadget (BIT_WIDTH 2) computes Gamma_1*Gamma_0 from shares plus r, p. Its internal registers load on acc only.
  - Share registers hold Gamma_1 and Gamma_0, loaded on acc.
  - After the registers, per share: x = mul ^ sigma_scale(sq(Gamma_1^Gamma_0)). Output share = sq(x), since squaring is inversion in GF(2^2).
- v1 sets on acc. v1 clears when stage 1 is drained and there is no acc.
- OUT_REG=1: stage 2 registers out_b and v2. It loads when stage 1 is valid and stage 2 can accept (!v2 | out_ready).
- Back-pressure, standard pipeline enable chain:
  - Stage k accepts when !v_k | (downstream of stage k accepts).
  - in_ready = stage-1 accept condition, which is independent of in_valid.
- Bubble handling: when a stage empties, data registers hold their old contents. Only the valid bit clears, so no re-masking occurs without fresh randomness.
- Lanes share one handshake and never diverge.
- Shares are never combined across share domains outside the HPC3 gadget. Unshared XOR of all shares of out_b equals theta_ref(XOR of in_a shares).

## Timing
- Reset (asynchronous, immediate):
  - All valids = 0, so out_valid = 0.
  - All data and gadget registers = 0, so out_b = all-zero shares for either OUT_REG.
  - in_ready = 1 once reset deasserts. in_ready is forced 0 while in_reset is high.
- Latency: acc in cycle t gives out_valid in cycle t+1 (OUT_REG=0) or t+2 (OUT_REG=1), provided out_ready stays high.
- Throughput: one element per cycle per lane with out_ready=1 and continuous valid inputs.
- out_ready=0 with out_valid=1:
  - out_b and out_valid stay stable.
  - in_ready drops once all stages are full. Full means in the same cycle for OUT_REG=0, and after one more accept for OUT_REG=1.
- Simultaneous drain and accept in a full pipeline with out_ready=1: no bubble is inserted.
- in_random_valid=0 with in_valid=1: nothing is accepted. in_ready is unaffected. The element is held upstream.
- Reset asserted mid-stream: in-flight elements are discarded with no partial output, and registers clear asynchronously.

## Test plan
- 2 shares, 1 lane, OUT_REG=0. Stream unshared a = 4'h0, 4'h5, 4'hA, 4'hF with random shares and random r/p -> unshared out_b = 2'b00, 2'b01, 2'b10, 2'b11, each 1 cycle after accept.
- Exhaustive 16 unshared values × random masks, NUM_SHARES=3, NUM_LANES=4, OUT_REG=1 -> every lane matches the bv2_mul/bv2_sq/bv2_scl_sigma golden model at latency 2, back-to-back.
- Back-pressure: OUT_REG=1, hold out_ready=0 for 5 cycles after 3 accepts. Required: only 2 accepted, out_b/out_valid stable, and in_ready low until out_ready rises. Then both elements drain in order with no loss or duplication.
- in_random_valid toggling 1,0,1,0 with in_valid=1 -> accepts only in the 1 cycles, and the gadget and share registers remain unchanged in the 0 cycles.
- Assert in_reset asynchronously between clock edges with 2 elements in flight. Required: out_valid=0 and out_b=0 immediately, and no stale output after release.
- Randomised stall/valid/random-valid traffic over 10k elements: scoreboard order and values exact, and the count of accepted elements equals the count of out_valid&out_ready cycles.
